pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Program-counter datapath slice of the single-cycle RV32 core: PC register, PC+4 incrementer, branch-target adder and next-PC select mux in one block.
- Consumes the extended immediate from the Extend unit, the ALU result used as the JALR target, and the 2-bit PCSrc from the control unit.
- Drives the current PC to instruction memory and PCPlus4 to the writeback path for JAL/JALR link values.

Parameters:
- XLEN, 32, datapath width of PC, immediates and addresses.
- RESET_VECTOR, 32'h00000000, value loaded into PC on reset.

Ports:
- clk  input  1  core clock; PC updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- PCSrc  input  2  next-PC select: 00 = PC+4, 01 = branch/JAL target, 10 = JALR address, 11 = PC+4.
- ImmExt  input  XLEN  sign-extended immediate offset from the Extend unit.
- jalr_address  input  XLEN  JALR target computed by the ALU.
- PC  output  XLEN  current program counter (registered).
- PCPlus4  output  XLEN  PC + 4 (combinational).
- PCTarget  output  XLEN  PC + ImmExt (combinational).
- PCNext  output  XLEN  selected next PC (combinational).

Behaviour:
- One clock domain (clk); reset is synchronous and active-high. Reset is sampled only on the rising edge of clk.
- PC register, per rising edge of clk:
  - If reset = 1: PC <= RESET_VECTOR.
  - Otherwise: PC <= PCNext.
  - Reset has priority over PCSrc.
- PC holds its value between edges. No enable or stall; PC advances every non-reset cycle.
- During and after reset, PCPlus4, PCTarget and PCNext keep computing combinationally from the current PC.
- PCPlus4 = PC + 4: unsigned XLEN-bit add, carry discarded. Example: FFFFFFFC -> 00000000.
- PCTarget = PC + ImmExt, XLEN-bit two's-complement add, carry discarded.
  - Negative offsets subtract naturally. Example: PC=00000010, ImmExt=FFFFFFF0 -> 00000000.
- PCNext select:
  - 00 -> PCPlus4.
  - 01 -> PCTarget.
  - 10 -> jalr_address.
  - 11 -> PCPlus4 (reserved code, defined fallback, never X).
- Latency:
  - PCPlus4, PCTarget and PCNext have zero-cycle latency from PC, PCSrc, ImmExt and jalr_address.
  - PC reflects PCNext one cycle after it is presented.
- No alignment checking. jalr_address passes through unmodified unless the optional feature is enabled; odd or misaligned targets are loaded as-is.
- Reset asserted mid-sequence forces PC to RESET_VECTOR on the next edge, regardless of PCSrc.
- Deasserting reset resumes normal selection on the following edge.
- No X-propagation from an unknown PCSrc into PC after reset. Treat any non-01/10 code as 00.

Optional Feature:
- Macro: JALR_LSB_CLEAR_EN.
- Defined: the PCSrc=10 path selects {jalr_address[XLEN-1:1], 1'b0}, i.e. RISC-V JALR bit-0 clearing inside the block.
- Undefined (default): jalr_address is selected unmodified; example 11111111 -> PC=11111111.
- PCPlus4 and PCTarget are unaffected either way.

Test Plan:
- Reset: reset=1 for one edge, any PCSrc -> PC=00000000, PCPlus4=00000004, PCNext=00000004 with PCSrc=00.
- Branch target: from PC=00000000, reset=0, PCSrc=01, ImmExt=16AB2D10, one edge -> PC=16AB2D10.
- Increment: then PCSrc=00, one edge -> PC=16AB2D14; a further edge -> 16AB2D18.
- JALR: from PC=00000000, PCSrc=10, jalr_address=11111111, one edge -> PC=11111111 (macro off) or 11111110 (JALR_LSB_CLEAR_EN on).
- Wrap and negative offset, each from its own reset/load setup:
  - PC=FFFFFFFC, PCSrc=00, one edge -> 00000000.
  - PC=00000010, ImmExt=FFFFFFF0, PCSrc=01, one edge -> 00000000.
  - PCSrc=11 -> PCNext equals PCPlus4.
- Reset mid-run: while PC=16AB2D14 with PCSrc=01, assert reset for one edge -> PC=00000000. Next edge with reset=0 applies PCSrc normally.

Source files
------------

// File: rtl/pc_next_unit.sv
// -----------------------------------------------------------------------------
// pc_next_unit
//
// This is the program-counter slice of the single-cycle RV32 core. It holds
// the PC register and computes PC+4 and the branch target PC+ImmExt. It also
// selects the next PC, which is loaded on every rising clock edge unless
// reset is asserted.
//
// Parameters:
//   XLEN          datapath width of PC, immediates and addresses
//   RESET_VECTOR  value loaded into PC by reset
//
// Ports:
//   clk           core clock; PC updates on the rising edge
//   reset         synchronous, active-high; forces PC to RESET_VECTOR
//   PCSrc         next-PC select: 00 PC+4, 01 PC+ImmExt, 10 JALR, 11 PC+4
//   ImmExt        sign-extended immediate offset from the Extend unit
//   jalr_address  JALR target computed by the ALU
//   PC            current program counter (registered)
//   PCPlus4       PC + 4 (combinational, goes to writeback as link value)
//   PCTarget      PC + ImmExt (combinational)
//   PCNext        selected next PC (combinational)
//
// Build option:
//   JALR_LSB_CLEAR_EN  When this macro is defined, the JALR path clears
//                      bit 0 of jalr_address, as RISC-V JALR requires.
//                      When it is undefined, jalr_address is used unmodified.
// -----------------------------------------------------------------------------
module pc_next_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] ImmExt,
  input  logic [XLEN-1:0] jalr_address,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic [XLEN-1:0] PCTarget,
  output logic [XLEN-1:0] PCNext
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Encodings of the PCSrc select input
  localparam logic [1:0] SRC_PLUS4  = 2'b00;
  localparam logic [1:0] SRC_TARGET = 2'b01;
  localparam logic [1:0] SRC_JALR   = 2'b10;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] pc_next;

  // Both adders wrap modulo 2^XLEN. A negative ImmExt subtracts through
  // two's-complement wraparound.
  always_comb begin
    pc_plus4  = pc_q + PC_STEP;
    pc_target = pc_q + ImmExt;
  end

`ifdef JALR_LSB_CLEAR_EN
  // RISC-V JALR clears bit 0 of the computed target.
  always_comb begin
    jalr_target = {jalr_address[XLEN-1:1], 1'b0};
  end
`else
  // The ALU result is used as-is. Odd or misaligned targets are loaded into
  // PC unchanged.
  always_comb begin
    jalr_target = jalr_address;
  end
`endif

  // The reserved code 11, and any code containing X or Z, fall through to
  // the default branch. An unknown select therefore yields PC+4 and never
  // propagates X into PC.
  always_comb begin
    pc_next = pc_plus4;
    case (PCSrc)
      SRC_PLUS4:  pc_next = pc_plus4;
      SRC_TARGET: pc_next = pc_target;
      SRC_JALR:   pc_next = jalr_target;
      default:    pc_next = pc_plus4;
    endcase
  end

  // Reset takes priority over any PCSrc selection. There is no stall, so
  // PC advances on every non-reset edge.
  always_comb begin
    pc_d = pc_next;
    if (reset) begin
      pc_d = RESET_VECTOR;
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  assign PC       = pc_q;
  assign PCPlus4  = pc_plus4;
  assign PCTarget = pc_target;
  assign PCNext   = pc_next;

endmodule

// File: tb/tb_pc_next_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_next_unit
//
// Directed testbench for pc_next_unit with scoreboard-based checking.
//
// The driver applies inputs on the falling edge of clk. For each step it
// pushes its expectations into a queue, and each entry carries the time at
// which it becomes observable:
//   - combinational outputs: 2 time units after the falling edge
//   - registered PC:         2 time units after the following rising edge
//
// A separate monitor wakes 2 time units after every clock edge. It pops
// every entry that is due and compares that entry against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pc_next_unit;

  localparam int XLEN = 32;

  // Codes for which DUT output an expectation refers to
  localparam int SIG_PC     = 0;
  localparam int SIG_PLUS4  = 1;
  localparam int SIG_TARGET = 2;
  localparam int SIG_NEXT   = 3;

  logic            clk;
  logic            reset;
  logic [1:0]      PCSrc;
  logic [XLEN-1:0] ImmExt;
  logic [XLEN-1:0] jalr_address;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PCPlus4;
  logic [XLEN-1:0] PCTarget;
  logic [XLEN-1:0] PCNext;

  pc_next_unit #(
    .XLEN(XLEN),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .PCSrc(PCSrc),
    .ImmExt(ImmExt),
    .jalr_address(jalr_address),
    .PC(PC),
    .PCPlus4(PCPlus4),
    .PCTarget(PCTarget),
    .PCNext(PCNext)
  );

  // 10-unit clock period: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    int              sig;
    logic [XLEN-1:0] exp;
    time             due;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  // JALR expectation for the odd target; it depends on the build option
`ifdef JALR_LSB_CLEAR_EN
  localparam logic [XLEN-1:0] JALR_ODD_EXP = 32'h1111_1110;
`else
  localparam logic [XLEN-1:0] JALR_ODD_EXP = 32'h1111_1111;
`endif

  // Wait for the falling edge, then apply one set of inputs
  task automatic drive(input logic rst, input logic [1:0] src,
                       input logic [XLEN-1:0] imm, input logic [XLEN-1:0] jalr);
    @(negedge clk);
    reset        = rst;
    PCSrc        = src;
    ImmExt       = imm;
    jalr_address = jalr;
  endtask

  // Expect a combinational output value while the current inputs are held
  task automatic expect_comb(input string name, input int sig, input logic [XLEN-1:0] val);
    exp_t e;
    e.name = name; e.sig = sig; e.exp = val; e.due = $time + 2;
    exp_q.push_back(e);
  endtask

  // Expect the PC value after the next rising edge
  task automatic expect_pc(input string name, input logic [XLEN-1:0] val);
    exp_t e;
    e.name = name; e.sig = SIG_PC; e.exp = val; e.due = $time + 7;
    exp_q.push_back(e);
  endtask

  function automatic logic [XLEN-1:0] dut_sig(input int sig);
    case (sig)
      SIG_PC:     return PC;
      SIG_PLUS4:  return PCPlus4;
      SIG_TARGET: return PCTarget;
      default:    return PCNext;
    endcase
  endfunction

  // Monitor: checks the expectations that are due, independently of the driver
  initial begin
    forever begin
      @(posedge clk or negedge clk);
      #2;
      while (exp_q.size() > 0 && exp_q[0].due <= $time) begin
        exp_t e;
        logic [XLEN-1:0] act;
        e   = exp_q.pop_front();
        act = dut_sig(e.sig);
        total_cnt++;
        if (act === e.exp) begin
          pass_cnt++;
          $display("t=%0t check %s: got %08h ok", $time, e.name, act);
        end else begin
          $display("FAIL t=%0t %s: actual %08h required %08h", $time, e.name, act, e.exp);
        end
      end
    end
  end

  // Watchdog: stops the run if the stimulus ever stalls
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    PCSrc        = 2'b01;
    ImmExt       = 32'h16AB_2D10;
    jalr_address = 32'h0;

    // Reset, with a non-zero PCSrc value present
    drive(1'b1, 2'b01, 32'h16AB_2D10, 32'h0);
    expect_pc("reset_pc", 32'h0000_0000);
    drive(1'b1, 2'b00, 32'h16AB_2D10, 32'h0);
    expect_comb("reset_plus4", SIG_PLUS4, 32'h0000_0004);
    expect_comb("reset_next00", SIG_NEXT, 32'h0000_0004);
    expect_pc("reset_hold_pc", 32'h0000_0000);

    // Branch target, then two increments
    drive(1'b0, 2'b01, 32'h16AB_2D10, 32'h0);
    expect_comb("branch_target", SIG_TARGET, 32'h16AB_2D10);
    expect_comb("branch_next", SIG_NEXT, 32'h16AB_2D10);
    expect_pc("branch_pc", 32'h16AB_2D10);
    drive(1'b0, 2'b00, 32'h0000_0040, 32'h0);
    expect_comb("inc1_plus4", SIG_PLUS4, 32'h16AB_2D14);
    expect_pc("inc1_pc", 32'h16AB_2D14);
    drive(1'b0, 2'b00, 32'h0000_0040, 32'h0);
    expect_pc("inc2_pc", 32'h16AB_2D18);

    // Return to 16AB2D14, then assert reset mid-run with PCSrc=01
    drive(1'b0, 2'b10, 32'h0, 32'h16AB_2D14);
    expect_pc("jalr_back_pc", 32'h16AB_2D14);
    drive(1'b1, 2'b01, 32'h0000_0100, 32'h0);
    expect_comb("midrst_target", SIG_TARGET, 32'h16AB_2E14);
    expect_pc("midrst_pc", 32'h0000_0000);
    drive(1'b0, 2'b01, 32'h0000_0100, 32'h0);
    expect_pc("after_rst_pc", 32'h0000_0100);

    // JALR with an odd target, starting from PC=0
    drive(1'b1, 2'b00, 32'h0, 32'h0);
    expect_pc("rst2_pc", 32'h0000_0000);
    drive(1'b0, 2'b10, 32'h0000_0020, 32'h1111_1111);
    expect_comb("jalr_next", SIG_NEXT, JALR_ODD_EXP);
    expect_comb("jalr_target_unaff", SIG_TARGET, 32'h0000_0020);
    expect_pc("jalr_pc", JALR_ODD_EXP);

    // PC+4 wraps from FFFFFFFC to 0
    drive(1'b0, 2'b10, 32'h0, 32'hFFFF_FFFC);
    expect_pc("load_fffffffc", 32'hFFFF_FFFC);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    expect_comb("wrap_plus4", SIG_PLUS4, 32'h0000_0000);
    expect_pc("wrap_pc", 32'h0000_0000);

    // Negative offset: 00000010 + FFFFFFF0 gives 0
    drive(1'b0, 2'b10, 32'h0, 32'h0000_0010);
    expect_pc("load_10", 32'h0000_0010);
    drive(1'b0, 2'b01, 32'hFFFF_FFF0, 32'h0);
    expect_comb("neg_target", SIG_TARGET, 32'h0000_0000);
    expect_pc("neg_pc", 32'h0000_0000);

    // The reserved code 11 behaves as PC+4
    drive(1'b0, 2'b11, 32'h0000_0040, 32'hDEAD_0000);
    expect_comb("src11_next", SIG_NEXT, 32'h0000_0004);
    expect_pc("src11_pc", 32'h0000_0004);
    drive(1'b0, 2'b11, 32'h0000_0040, 32'hDEAD_0000);
    expect_comb("src11_next2", SIG_NEXT, 32'h0000_0008);
    expect_comb("src11_target", SIG_TARGET, 32'h0000_0044);
    expect_pc("src11_pc2", 32'h0000_0008);

    // Let the monitor drain the queue, then confirm nothing was left behind
    @(negedge clk);
    repeat (2) @(posedge clk);
    #3;
    total_cnt++;
    if (exp_q.size() == 0) begin
      pass_cnt++;
    end else begin
      $display("FAIL scoreboard_drain: actual %0d pending required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
